// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control for load-use, redirect and data-memory wait with timeout.
// Optional HAZARD_PERF_EN adds saturating stall_cycles / flush_events counters.
module hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        ex_redirect,
  input  logic        mem_access,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        pc_write,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_flush,
  output logic [1:0]  state,
`ifdef HAZARD_PERF_EN
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events,
`endif
  output logic        err
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);
  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_err;
  logic       w_mem_stall, w_load_use, w_hold, w_err_st, w_run, w_redir, w_lu;
  assign w_mem_stall = mem_access & ~dmem_ready;
  assign w_load_use  = ex_memread & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  // MEM_WAIT keeps the pipe frozen until ready, regardless of mem_access
  assign w_hold   = (r_state == RUN) ? w_mem_stall : (r_state == MEM_WAIT) ? ~dmem_ready : 1'b0;
  assign w_err_st = (r_state == ERROR);
  assign w_run    = ~reset & ~w_hold & ~w_err_st;
  assign w_redir  = w_run & ex_redirect;
  assign w_lu     = w_run & ~ex_redirect & w_load_use;
  assign pc_write    = w_run & ~w_lu;
  assign ifid_en     = w_run & ~w_lu;
  assign idex_en     = w_run;
  assign exmem_en    = w_run;
  assign memwb_en    = w_run;
  assign ifid_flush  = reset | w_redir;
  assign idex_flush  = reset | w_redir | w_lu;
  assign memwb_flush = reset | w_hold;
  assign dmem_req    = ~reset & mem_access & ~w_err_st;
  assign state       = r_state;
  assign err         = r_err;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
    end else if (r_state == RUN && w_mem_stall) begin
      r_state <= MEM_WAIT;
      r_cnt   <= 8'd1;
    end else if (r_state == MEM_WAIT) begin
      if (dmem_ready) begin
        r_state <= RUN;
        r_cnt   <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
        if (r_cnt == LAST) begin
          r_state <= ERROR;
          r_err   <= 1'b1;
        end
      end
    end
  end
`ifdef HAZARD_PERF_EN
  logic [15:0] r_stall, r_flush;
  assign stall_cycles = r_stall;
  assign flush_events = r_flush;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= 16'd0;
      r_flush <= 16'd0;
    end else begin
      if (~pc_write && ~w_err_st && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
      if (w_redir && r_flush != 16'hFFFF) r_flush <= r_flush + 16'd1;
    end
  end
`endif
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum consecutive cycles spent waiting for dmem_ready before the block declares an error (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port id_rs1  input  5  rs1 field of the instruction held in the IF/ID register.
REQ-005 SHALL have port id_rs2  input  5  rs2 field of the instruction held in the IF/ID register.
REQ-006 SHALL have port ex_rd  input  5  rd held in the ID/EX register.
REQ-007 SHALL have port ex_memread  input  1  MemRead held in the ID/EX register.
REQ-008 SHALL have port ex_redirect  input  1  taken branch or jump resolved in EX.
REQ-009 SHALL have port mem_access  input  1  MemRead or MemWrite held in the EX/MEM register.
REQ-010 SHALL have port dmem_ready  input  1  data memory completes the current access this cycle.
REQ-011 SHALL have port dmem_req  output  1  data memory access request.
REQ-012 SHALL have port pc_write  output  1  PC update enable.
REQ-013 SHALL have ports ifid_en, idex_en, exmem_en, memwb_en  output  1 each  pipeline register load enables.
REQ-014 SHALL have ports ifid_flush, idex_flush, memwb_flush  output  1 each  load a bubble (all control bits 0) instead of the next-stage data.
REQ-015 SHALL have port state  output  2  FSM state: RUN=0, MEM_WAIT=1, ERROR=2.
REQ-016 SHALL have port err  output  1  sticky data-memory timeout flag.

Function
REQ-017 Outputs SHALL be combinational decodes of state and the current inputs; state, the wait counter and err SHALL be registered.
REQ-018 mem_stall SHALL equal mem_access AND NOT dmem_ready; dmem_req SHALL equal mem_access in RUN and MEM_WAIT, and SHALL be 0 in ERROR.
REQ-019 load_use SHALL equal ex_memread AND ex_rd!=0 AND (ex_rd==id_rs1 OR ex_rd==id_rs2).
REQ-020 In RUN with mem_stall: all enables 0, memwb_flush 1, other flushes 0; next state MEM_WAIT; wait counter loads 1.
REQ-021 In RUN without mem_stall and with ex_redirect: all enables 1, pc_write 1, ifid_flush 1, idex_flush 1; redirect SHALL take priority over load_use.
REQ-022 In RUN with only load_use asserted: pc_write 0, ifid_en 0, idex_en 1 with idex_flush 1, exmem_en and memwb_en 1, giving exactly one bubble per detected hazard.
REQ-023 In RUN with no condition asserted: all enables and pc_write 1, all flushes 0.
REQ-024 In MEM_WAIT with dmem_ready 0: same outputs as REQ-020; wait counter increments; when the counter equals TIMEOUT_CYCLES-1 the next state SHALL be ERROR and err SHALL set.
REQ-025 In MEM_WAIT with dmem_ready 1: outputs SHALL follow REQ-021..023 evaluated on the current inputs; next state RUN; counter clears.
REQ-026 ERROR: all enables and pc_write 0, all flushes 0; SHALL remain in ERROR until reset.
REQ-027 The wait counter SHALL be 8 bits and SHALL not wrap, because the ERROR transition fires first.

Reset
REQ-028 While reset is asserted: state=RUN, counter=0, err=0; all enables, pc_write and dmem_req 0; ifid_flush, idex_flush and memwb_flush 1.
REQ-029 Reset asserted mid-wait or in ERROR SHALL abort the operation immediately and return to REQ-028 values with no pending state.

Configuration
REQ-030 With macro HAZARD_PERF_EN defined, outputs stall_cycles (16) and flush_events (16) SHALL exist.
REQ-031 stall_cycles SHALL count cycles with pc_write=0 outside ERROR; flush_events SHALL count REQ-021 cycles.
REQ-032 Both counters SHALL saturate at 0xFFFF and clear on reset.
REQ-033 Without HAZARD_PERF_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 ex_memread=1, ex_rd=5, id_rs2=5 for one cycle -> pc_write=0, ifid_en=0, idex_flush=1 for one cycle; ex_rd=0 with id_rs1=0 -> no stall.
REQ-035 ex_redirect=1 together with a load_use match -> ifid_flush=1, idex_flush=1, pc_write=1; no stall.
REQ-036 mem_access=1, dmem_ready held 0 for 3 cycles then 1 -> state=1 for 3 cycles, memwb_flush=1 during the wait, return to RUN, err=0.
REQ-037 TIMEOUT_CYCLES=4, dmem_ready never asserted -> state=2 and err=1 after 4 stalled cycles; enables stay 0 until reset, then REQ-028 values.
REQ-038 Reset asserted during MEM_WAIT -> state=0 immediately (asynchronous); with HAZARD_PERF_EN, stall_cycles=0 after reset and reaches 3 after scenario REQ-036.
